alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
- Shares one 32-bit ALU (add/sub/slt/sltu/logic) between two requesters, e.g. the main datapath and a branch-compare unit.
- Round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Result is registered and held in a one-entry response buffer until the owning requester accepts it.
- At most one operation is outstanding at a time.

Parameters:
- WIDTH, 32, operand/result width (ALU core supports 32 only; kept for package consistency)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  3  ALU opcode (see Behaviour)
- req0_rs  in  WIDTH  operand A
- req0_rt  in  WIDTH  operand B
- req1_valid, req1_ready, req1_op, req1_rs, req1_rt: same as requester 0, for requester 1
- rsp0_valid  out  1  result for requester 0 is valid
- rsp0_ready  in  1  requester 0 takes the result
- rsp0_rd  out  WIDTH  result
- rsp0_overflow  out  1  signed overflow flag
- rsp1_valid, rsp1_ready, rsp1_rd, rsp1_overflow: same as requester 0, for requester 1

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, rr_ptr=0 (requester 0 has priority)
  - rsp*_valid=0, rsp*_rd=0, rsp*_overflow=0
  - any pending result is discarded
- Opcodes:
  - 000 ADD: rd=rs+rt; overflow=signed overflow
  - 001 SUB: rd=rs-rt; overflow=signed overflow
  - 010 SLT: rd={31'b0, $signed(rs)<$signed(rt)}; overflow=0
  - 011 SLTU: rd={31'b0, rs<rt unsigned}; overflow=0
  - 100 AND, 101 OR, 110 XOR, 111 NOR: bitwise; overflow=0
- States:
  - IDLE: no result held.
  - HOLD: result held for owner (owner bit registered).
- Grant, combinational:
  - Grant is possible when state==IDLE, or when state==HOLD and the owner's rsp_ready=1 this cycle (pass-through; back-to-back issue every cycle).
  - Only one valid: that requester is granted.
  - Both valid: grant the requester selected by rr_ptr.
  - reqN_ready = grant_possible & grantN. The non-granted ready is 0. Ready never rises without grant_possible.
- On request handshake (reqN_valid & reqN_ready) at edge N:
  - ALU result is captured into the buffer; owner=N.
  - rr_ptr = ~N.
  - state=HOLD; rspN_valid=1 from cycle N+1. Latency is 1 cycle.
- In HOLD without owner rsp_ready:
  - rd, overflow and rsp_valid are held stable.
  - No new grant.
  - The other rsp_valid stays 0.
- Owner handshake with no new grant: state=IDLE, rsp_valid drops next cycle.
- Owner handshake plus new grant in the same cycle: buffer reloads and the new owner's rsp_valid=1 next cycle, with no bubble.
- rr_ptr changes only on a grant. Idle cycles do not move it.
- Inputs with valid=0 are don't-care. Opcode and operands are sampled only at the handshake edge.
- Reset mid-HOLD: the result is dropped and no rsp_valid is seen after reset.

Decomposition:
- Package alu_pkg:
  - opcode localparams: ALU_ADD … ALU_NOR
  - state encodings: ST_IDLE, ST_HOLD
- Sub-module alu_core: purely combinational.
  - ports: rs, rt, op → rd, overflow
  - implements the opcode table
  - unit-testable standalone
- alu_share_arb contains:
  - arbiter and rr_ptr
  - FSM
  - response buffer
  - handshake logic

Test Plan:
- Reset, then req0 SLTU rs=0x7fffffff rt=0xfffffff9, rsp0_ready=1 → rsp0_valid next cycle, rd=1, ov=0. Then SLT rs=0x80000000 rt=0x9 → rd=1.
- req1 ADD 0x7fffffff+0x1 → rsp1_rd=0x80000000, ov=1. Then SUB 0x80000000-0x1 → rd=0x7fffffff, ov=1. rsp0_valid stays 0 throughout.
- Both valid for 4 cycles, rsp ready=1 → grants alternate 0,1,0,1. One result per cycle, rsp owner alternating, no bubbles.
- req0 SLTU 0xfffffff3 vs 0xffff0003 (rd=0), rsp0_ready=0 for 3 cycles → rd/valid stable, req0_ready=req1_ready=0. Release → handshake; a waiting req1 is granted in the same cycle.
- rst_n=0 while HOLD → next cycle all rsp_valid=0, rd=0. First post-reset contention grants req0.
- Full opcode sweep via alu_core with rs=0xa, rt=0x4 → ADD 0xe, SUB 0x6, SLT 0, SLTU 0, AND 0x0, OR 0xe, XOR 0xe, NOR 0xfffffff1.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg : opcode and FSM state encodings shared by the ALU arbiter slice
// Rev 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_NOR  = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_core : combinational 32-bit ALU (add/sub/slt/sltu/and/or/xor/nor)
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] rd,
  output logic             overflow
);

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_slt;
  logic             w_sltu;

  assign w_sum  = rs + rt;
  assign w_diff = rs - rt;
  assign w_slt  = $signed(rs) < $signed(rt);
  assign w_sltu = rs < rt;

  always_comb begin
    rd       = '0;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        rd       = w_sum;
        // Same-sign operands producing an opposite-sign result.
        overflow = (rs[WIDTH-1] == rt[WIDTH-1]) && (w_sum[WIDTH-1] != rs[WIDTH-1]);
      end
      ALU_SUB: begin
        rd       = w_diff;
        overflow = (rs[WIDTH-1] != rt[WIDTH-1]) && (w_diff[WIDTH-1] != rs[WIDTH-1]);
      end
      ALU_SLT:  rd = {{(WIDTH-1){1'b0}}, w_slt};
      ALU_SLTU: rd = {{(WIDTH-1){1'b0}}, w_sltu};
      ALU_AND:  rd = rs & rt;
      ALU_OR:   rd = rs | rt;
      ALU_XOR:  rd = rs ^ rt;
      ALU_NOR:  rd = ~(rs | rt);
      default: begin
        rd       = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_share_arb : round-robin sharing of one ALU between two requesters with
//                 a one-entry registered response buffer.  Rev 1.0
// ---------------------------------------------------------------------------
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_rs,
  input  logic [WIDTH-1:0] req0_rt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_rs,
  input  logic [WIDTH-1:0] req1_rt,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_rd,
  output logic             rsp0_overflow,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_rd,
  output logic             rsp1_overflow
);

  state_t           r_state;
  logic             r_owner;
  logic             r_rr;
  logic [WIDTH-1:0] r_rd;
  logic             r_ov;
  logic [1:0]       r_rsp_valid;

  logic             w_owner_ready;
  logic             w_grant_ok;
  logic             w_grant0;
  logic             w_grant1;
  logic [2:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_rs;
  logic [WIDTH-1:0] w_sel_rt;
  logic [WIDTH-1:0] w_alu_rd;
  logic             w_alu_ov;

  // A held result that is being consumed this cycle frees the buffer,
  // allowing a new issue with no bubble.
  assign w_owner_ready = r_owner ? rsp1_ready : rsp0_ready;
  assign w_grant_ok    = (r_state == ST_IDLE) || w_owner_ready;

  assign w_grant0 = w_grant_ok && req0_valid && (!req1_valid || !r_rr);
  assign w_grant1 = w_grant_ok && req1_valid && (!req0_valid ||  r_rr);

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  assign w_sel_op = w_grant1 ? req1_op : req0_op;
  assign w_sel_rs = w_grant1 ? req1_rs : req0_rs;
  assign w_sel_rt = w_grant1 ? req1_rt : req0_rt;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .rs       (w_sel_rs),
    .rt       (w_sel_rt),
    .op       (w_sel_op),
    .rd       (w_alu_rd),
    .overflow (w_alu_ov)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= 1'b0;
      r_rr        <= 1'b0;
      r_rd        <= '0;
      r_ov        <= 1'b0;
      r_rsp_valid <= 2'b00;
    end else if (w_grant0 || w_grant1) begin
      r_state     <= ST_HOLD;
      r_owner     <= w_grant1;
      r_rr        <= !w_grant1;
      r_rd        <= w_alu_rd;
      r_ov        <= w_alu_ov;
      r_rsp_valid <= {w_grant1, w_grant0};
    end else if ((r_state == ST_HOLD) && w_owner_ready) begin
      r_state     <= ST_IDLE;
      r_rsp_valid <= 2'b00;
    end
  end

  assign rsp0_valid    = r_rsp_valid[0];
  assign rsp1_valid    = r_rsp_valid[1];
  assign rsp0_rd       = r_rd;
  assign rsp1_rd       = r_rd;
  assign rsp0_overflow = r_ov;
  assign rsp1_overflow = r_ov;

endmodule
`default_nettype wire
